adc128s_serf: RTL and testbench
===============================

# adc128s_serf

SPI responder that emulates the serial side of an ADC128S-style 8-channel, 12-bit converter. It sits opposite the A2D interface master: it decodes the 16-bit command word on MOSI, holds the selected channel, and returns that channel's 12-bit sample on MISO during the following frame. It is used as a synthesizable ADC stand-in for full-chip simulation and FPGA bring-up, fed from the analog-value sources in the bench or the board.

## Interface
- No parameters.
- clk  input  1  system clock; SCLK runs at 1/32 of clk or slower.
- rst_n  input  1  reset, asynchronous, active-low.
- SS_n  input  1  slave select from master, active-low, async to clk.
- SCLK  input  1  serial clock from master, idles high, async to clk.
- MOSI  input  1  command data from master, async to clk.
- ch_data  input  96  sample values; channel n at ch_data[12n+11:12n].
- MISO  output  1  serial response, MSB first.
- chnnl  output  3  channel captured from the last complete frame.
- cmd_vld  output  1  one-clk pulse when a complete 16-bit frame ends.
- frm_err  output  1  one-clk pulse when a frame ends with bit count ≠ 16.

## Operation
- Synchronizers: SS_n, SCLK, MOSI each pass through two flops, then a third flop for edge detect. Reset value 1 for all nine flops.
- Edge events (single-clk): ss_fall, ss_rise, sclk_rise, sclk_fall, derived from flop 2 vs flop 3.
- State machine:
  - IDLE: synced SS_n high. On ss_fall: load tx_shft <= {4'h0, ch_data[12*chnnl +: 12]}, clear bit_cnt, go ARMED.
  - ARMED: SS_n low, no SCLK rise yet. sclk_fall ignored (master's front-porch fall). On sclk_rise: rx_shft <= {rx_shft[14:0], MOSI_sync}, bit_cnt++, go SHIFT.
  - SHIFT: sclk_rise shifts rx_shft in and increments bit_cnt; sclk_fall shifts tx_shft left, filling 0.
  - ss_rise from ARMED or SHIFT: go IDLE; if bit_cnt == 16, chnnl <= rx_shft[13:11] and pulse cmd_vld; else pulse frm_err, chnnl unchanged.
- bit_cnt is 5 bits, saturates at 31; more than 16 rises yields frm_err.
- rx_shft bits [15:14] and [10:0] are don't-care; no error on nonzero reserved bits.
- MISO = tx_shft[15] while synced SS_n low, else 1.
- Sample selection uses chnnl at SS_n fall; ch_data changes after ss_fall do not affect the current frame.
- Result: frame N returns the channel commanded in frame N-1 (ADC128S pipelining); first frame after reset returns channel 0.

## Timing
- Pin-to-event latency: 3 clk from a pin edge to its ss/sclk event.
- MISO updates 1 clk after sclk_fall event (4 clk after pin fall); master samples on next rise ≥16 clk later.
- tx_shft loaded 1 clk after ss_fall event; first bit valid on MISO before the first SCLK rise (master front porch ≥ 16 clk).
- chnnl, cmd_vld, frm_err update on the clk following the ss_rise event.
- Simultaneous ss_rise and sclk_rise event in the same clk: SS_n wins; the edge is not counted.
- Reset values: MISO 1, chnnl 0, cmd_vld 0, frm_err 0, tx_shft 0, rx_shft 0, bit_cnt 0, state IDLE.
- Reset mid-frame: immediate return to IDLE; the partial frame is discarded; SS_n must go high and fall again before a new frame is accepted.

## Test plan
- Reset with SS_n/SCLK high → MISO=1, chnnl=0, no pulses for 100 clk.
- ch_data[0]=0x123, ch_data[4]=0xABC; frame 0x2000 then 0x2000 → frame 1 returns 0x0123, frame 2 returns 0x0ABC; chnnl=4 after frame 1; cmd_vld pulses once per frame.
- Round robin commands 0x0000, 0x2000, 0x2800, 0x3000 (ch 0,4,5,6) with distinct ch_data → each read returns the previous command's channel value.
- Abort after 8 SCLK rises (SS_n high) → frm_err single pulse, no cmd_vld, chnnl unchanged; next full frame returns the pre-abort channel.
- ch_data[chnnl] changed from 0x555 to 0xAAA mid-frame → MISO still returns 0x0555; next frame returns 0x0AAA.
- Assert rst_n at bit 9 of a frame → outputs return to reset values; after SS_n high/low a full frame completes with cmd_vld and correct data.

Source files
------------

// File: rtl/adc128s_serf_if.sv
// adc128s_serf_if
// Serial (SPI) pins between the A2D interface master and the ADC stand-in.
//   SS_n  : slave select, active-low, driven by master
//   SCLK  : serial clock, idles high, driven by master
//   MOSI  : command data, driven by master
//   MISO  : response data, driven by the ADC responder
interface adc128s_serf_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (output SS_n, output SCLK, output MOSI, input MISO);
    modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/adc128s_serf.sv
// adc128s_serf
// Synthesizable ADC128S-style serial responder: decodes the 16-bit command
// on MOSI, remembers the commanded channel and returns the previously
// commanded channel's 12-bit sample on MISO (MSB first, 4 leading zeros).
// Ports:
//   clk      : system clock (SCLK is at most clk/32)
//   rst_n    : asynchronous active-low reset
//   spi      : SPI pins (slave modport), all async to clk
//   ch_data  : 8 x 12-bit sample values, channel n at [12n+11:12n]
//   chnnl    : channel captured from the last complete 16-bit frame
//   cmd_vld  : one-clk pulse when a 16-bit frame completes
//   frm_err  : one-clk pulse when a frame ends with a bit count other than 16
//
// state | meaning
// IDLE  | SS_n high (or frame not yet allowed after reset)
// ARMED | SS_n low, response loaded, waiting for first SCLK rise
// SHIFT | frame in progress, rises shift MOSI in, falls shift MISO out
module adc128s_serf (
    input  logic              clk,
    input  logic              rst_n,
    adc128s_serf_if.slave     spi,
    input  logic [95:0]       ch_data,
    output logic [2:0]        chnnl,
    output logic              cmd_vld,
    output logic              frm_err
);

    typedef enum logic [1:0] {IDLE, ARMED, SHIFT} state_t;

    state_t      state, state_nxt;
    logic [2:0]  ss_q, sclk_q, mosi_q;
    logic        ss_fall, ss_rise, sclk_rise, sclk_fall;
    logic [1:0]  settle;
    logic        ss_ok;
    logic [15:0] tx_shft;
    // Only bits [13:11] of the command are ever read, so the MSB is not kept.
    logic [14:0] rx_shft;
    logic [4:0]  bit_cnt;
    logic [11:0] sample_sel;
    logic        ld_tx, rx_step, tx_step, frame_ok, frame_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_q   <= 3'b111;
            sclk_q <= 3'b111;
            mosi_q <= 3'b111;
        end else begin
            ss_q   <= {ss_q[1:0], spi.SS_n};
            sclk_q <= {sclk_q[1:0], spi.SCLK};
            mosi_q <= {mosi_q[1:0], spi.MOSI};
        end
    end

    assign ss_fall   =  ss_q[2]   & ~ss_q[1];
    assign ss_rise   = ~ss_q[2]   &  ss_q[1];
    assign sclk_rise = ~sclk_q[2] &  sclk_q[1];
    assign sclk_fall =  sclk_q[2] & ~sclk_q[1];

    // The synchronizers come out of reset holding 1, so an SS_n pin that is
    // already low would look like a fresh fall. A frame is only accepted once
    // a real (post-reset) sample of SS_n has been seen high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle <= 2'd0;
            ss_ok  <= 1'b0;
        end else begin
            if (settle != 2'd2)
                settle <= settle + 2'd1;
            if (settle == 2'd2 && ss_q[1])
                ss_ok <= 1'b1;
        end
    end

    always_comb begin
        sample_sel = 12'h000;
        for (int i = 0; i < 8; i++) begin
            if (chnnl == i[2:0])
                sample_sel = ch_data[12*i +: 12];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ld_tx     = 1'b0;
        rx_step   = 1'b0;
        tx_step   = 1'b0;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall && ss_ok) begin
                    ld_tx     = 1'b1;
                    state_nxt = ARMED;
                end
            end
            ARMED: begin
                // SS_n rise takes priority over a coincident SCLK rise.
                if (ss_rise) begin
                    state_nxt = IDLE;
                    frame_ok  = (bit_cnt == 5'd16);
                    frame_bad = (bit_cnt != 5'd16);
                end else if (sclk_rise) begin
                    rx_step   = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    state_nxt = IDLE;
                    frame_ok  = (bit_cnt == 5'd16);
                    frame_bad = (bit_cnt != 5'd16);
                end else begin
                    rx_step = sclk_rise;
                    tx_step = sclk_fall;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shft <= 16'h0000;
            rx_shft <= 15'h0000;
            bit_cnt <= 5'd0;
            chnnl   <= 3'd0;
            cmd_vld <= 1'b0;
            frm_err <= 1'b0;
        end else begin
            cmd_vld <= frame_ok;
            frm_err <= frame_bad;
            if (frame_ok)
                chnnl <= rx_shft[13:11];
            if (ld_tx) begin
                tx_shft <= {4'h0, sample_sel};
                bit_cnt <= 5'd0;
            end else if (tx_step) begin
                tx_shft <= {tx_shft[14:0], 1'b0};
            end
            if (rx_step) begin
                rx_shft <= {rx_shft[13:0], mosi_q[2]};
                if (bit_cnt != 5'd31)
                    bit_cnt <= bit_cnt + 5'd1;
            end
        end
    end

    assign spi.MISO = ss_q[1] ? 1'b1 : tx_shft[15];

endmodule

// File: tb/tb_adc128s_serf.sv
module tb_adc128s_serf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [95:0] ch_data;
    logic [2:0]  chnnl;
    logic        cmd_vld, frm_err;

    adc128s_serf_if spi ();

    adc128s_serf dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .spi     (spi),
        .ch_data (ch_data),
        .chnnl   (chnnl),
        .cmd_vld (cmd_vld),
        .frm_err (frm_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_vld = 0;
    int n_err = 0;
    int sclk_rises = 0;
    logic [11:0] mch [8];
    int m_ch = 0;

    always @(negedge clk) begin
        if (cmd_vld) n_vld++;
        if (frm_err) n_err++;
    end

    typedef struct {
        logic [15:0] cmd;
        int          rises;
        logic [15:0] data;
        logic [2:0]  ch;
        logic        vld;
        logic        err;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pack_ch();
        for (int i = 0; i < 8; i++) ch_data[12*i +: 12] = mch[i];
    endtask

    task automatic spi_frame(input logic [15:0] cmd, input int rises, output logic [31:0] rx);
        rx = 32'h0;
        spi.SS_n = 1'b0;
        spi.MOSI = cmd[15];
        wait_clk(16);
        spi.SCLK = 1'b0;
        wait_clk(16);
        for (int i = 0; i < rises; i++) begin
            spi.SCLK = 1'b1;
            sclk_rises++;
            rx = {rx[30:0], spi.MISO};
            wait_clk(16);
            if (i < rises - 1) begin
                spi.SCLK = 1'b0;
                spi.MOSI = (i < 15) ? cmd[14-i] : 1'b0;
                wait_clk(16);
            end
        end
        spi.SS_n = 1'b1;
        wait_clk(8);
        spi.SCLK = 1'b1;
        wait_clk(12);
    endtask

    task automatic do_frame(input string name, input logic [15:0] cmd, input int rises,
                            input logic [15:0] exp_data, input logic [2:0] exp_ch,
                            input logic exp_vld, input logic exp_err);
        logic [31:0] rx, exp_rx;
        int v0, e0;
        v0 = n_vld;
        e0 = n_err;
        spi_frame(cmd, rises, rx);
        if (rises <= 16) exp_rx = {16'h0, exp_data} >> (16 - rises);
        else             exp_rx = {16'h0, exp_data} << (rises - 16);
        check({name, "_miso"}, rx, exp_rx);
        check({name, "_chnnl"}, {29'h0, chnnl}, {29'h0, exp_ch});
        check({name, "_vld"}, n_vld - v0, {31'h0, exp_vld});
        check({name, "_err"}, n_err - e0, {31'h0, exp_err});
    endtask

    // Reference model: a frame returns the sample of the channel held when
    // SS_n falls; only an exactly-16-rise frame updates the held channel.
    task automatic model_frame(input string name, input logic [15:0] cmd, input int rises);
        logic [15:0] exp_data;
        logic        ok;
        exp_data = {4'h0, mch[m_ch]};
        ok = (rises == 16);
        if (ok) m_ch = int'(cmd[13:11]);
        do_frame(name, cmd, rises, exp_data, m_ch[2:0], ok, !ok);
    endtask

    initial begin
        int bad, base, to;
        logic [31:0] rx;

        spi.SS_n = 1'b1;
        spi.SCLK = 1'b1;
        spi.MOSI = 1'b0;
        mch[0] = 12'h123; mch[1] = 12'h111; mch[2] = 12'h222; mch[3] = 12'h333;
        mch[4] = 12'hABC; mch[5] = 12'h5A5; mch[6] = 12'h6C6; mch[7] = 12'h777;
        pack_ch();

        tbl[0]  = '{16'h2000, 16, 16'h0123, 3'd4, 1'b1, 1'b0};
        tbl[1]  = '{16'h2000, 16, 16'h0ABC, 3'd4, 1'b1, 1'b0};
        tbl[2]  = '{16'h0000, 16, 16'h0ABC, 3'd0, 1'b1, 1'b0};
        tbl[3]  = '{16'h2000, 16, 16'h0123, 3'd4, 1'b1, 1'b0};
        tbl[4]  = '{16'h2800, 16, 16'h0ABC, 3'd5, 1'b1, 1'b0};
        tbl[5]  = '{16'h3000, 16, 16'h05A5, 3'd6, 1'b1, 1'b0};
        tbl[6]  = '{16'h0000, 16, 16'h06C6, 3'd0, 1'b1, 1'b0};
        tbl[7]  = '{16'h3800,  8, 16'h0123, 3'd0, 1'b0, 1'b1};
        tbl[8]  = '{16'h2000, 16, 16'h0123, 3'd4, 1'b1, 1'b0};
        tbl[9]  = '{16'h1800, 20, 16'h0ABC, 3'd4, 1'b0, 1'b1};
        tbl[10] = '{16'h7FFF, 16, 16'h0ABC, 3'd7, 1'b1, 1'b0};
        tbl[11] = '{16'h0000, 16, 16'h0777, 3'd0, 1'b1, 1'b0};

        wait_clk(5);
        rst_n = 1'b1;

        // Reset / idle behaviour
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (spi.MISO !== 1'b1 || chnnl !== 3'd0 || cmd_vld !== 1'b0 || frm_err !== 1'b0)
                bad++;
        end
        check("reset_idle_bad_cycles", bad, 0);
        check("reset_miso", {31'h0, spi.MISO}, 32'h1);
        check("reset_chnnl", {29'h0, chnnl}, 32'h0);

        // Directed table
        for (int i = 0; i < 12; i++)
            do_frame($sformatf("tbl%0d", i), tbl[i].cmd, tbl[i].rises, tbl[i].data,
                     tbl[i].ch, tbl[i].vld, tbl[i].err);
        m_ch = 0;

        // Sample changed mid-frame must not disturb the frame in progress
        mch[0] = 12'h555;
        pack_ch();
        fork
            model_frame("midchg", 16'h0000, 16);
            begin
                wait_clk(100);
                mch[0] = 12'hAAA;
                pack_ch();
            end
        join
        model_frame("after_chg", 16'h0000, 16);

        // Reset asserted at bit 9 of a frame
        base = sclk_rises;
        fork
            spi_frame(16'h3000, 16, rx);
            begin
                to = 0;
                while (sclk_rises < base + 9 && to < 5000) begin
                    @(negedge clk);
                    to++;
                end
                check("rst_mid_wait_timeout", {31'h0, to >= 5000}, 32'h0);
                rst_n = 1'b0;
                wait_clk(2);
                check("rst_mid_miso", {31'h0, spi.MISO}, 32'h1);
                check("rst_mid_chnnl", {29'h0, chnnl}, 32'h0);
                check("rst_mid_pulses", {30'h0, cmd_vld, frm_err}, 32'h0);
                base = n_vld + n_err;
                rst_n = 1'b1;
            end
        join
        check("rst_mid_no_pulse_after", n_vld + n_err - base, 0);
        m_ch = 0;
        model_frame("post_rst", 16'h2800, 16);

        // Randomized frames against the model
        for (int k = 0; k < 25; k++) begin
            int rises;
            logic [15:0] cmd;
            for (int i = 0; i < 8; i++) mch[i] = 12'($urandom_range(0, 4095));
            pack_ch();
            cmd = 16'($urandom);
            rises = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : 16;
            model_frame($sformatf("rnd%0d", k), cmd, rises);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
